id_ex_skid_reg: RTL and testbench

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_skid_reg.sv | 135 +++++++++++++
 tb/tb_id_ex_skid_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register built as a 2-entry skid buffer carrying multi-lane issue bundles.
// in_ready is fully registered, so out_ready never reaches it combinationally.
module id_ex_skid_reg #(
    parameter int unsigned LANES = 2,
    parameter int unsigned PAY_W = 122,
    parameter int unsigned SB_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_vld,
    input  logic [LANES*PAY_W-1:0]   in_payload,
    input  logic [SB_W-1:0]          in_sideband,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_vld,
    output logic [LANES*PAY_W-1:0]   out_payload,
    output logic [SB_W-1:0]          out_sideband,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned DW = LANES * PAY_W;

    typedef struct packed {
        logic [SB_W-1:0]  sb;
        logic [LANES-1:0] lv;
        logic [DW-1:0]    pay;
    } bundle_t;

    bundle_t          main_q, main_d, skid_q, skid_d, in_b;
    logic [1:0]       occ_q, occ_d;
    logic             rdy_q, rdy_d, vld_q, vld_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             push, pop;

    // Zero the payload of invalid lanes before it is stored
    always_comb begin
        in_b.sb  = in_sideband;
        in_b.lv  = in_lane_vld;
        in_b.pay = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_lane_vld[i]) begin
                in_b.pay[i*PAY_W +: PAY_W] = in_payload[i*PAY_W +: PAY_W];
            end
        end
    end

    // All-lanes-invalid bundles are accepted but never stored
    assign push = in_valid & rdy_q & (|in_lane_vld);
    assign pop  = vld_q & out_ready;

    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        occ_d   = occ_q;
        stall_d = stall_q;

        if (vld_q && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            main_d = '0;
            skid_d = '0;
            occ_d  = 2'd0;
        end else begin
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        main_d = in_b;
                        occ_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && push) begin
                        main_d = in_b;
                    end else if (pop) begin
                        main_d = '0;
                        occ_d  = 2'd0;
                    end else if (push) begin
                        skid_d = in_b;
                        occ_d  = 2'd2;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        main_d = skid_q;
                        skid_d = '0;
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    main_d = '0;
                    skid_d = '0;
                    occ_d  = 2'd0;
                end
            endcase
        end

        vld_d = (occ_d != 2'd0);
        rdy_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = vld_q;
    assign out_lane_vld = main_q.lv;
    assign out_payload  = main_q.pay;
    assign out_sideband = main_q.sb;
    assign occupancy    = occ_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomized bench for id_ex_skid_reg against a queue-based bundle model.
module tb_id_ex_skid_reg;

    localparam int unsigned LANES = 2;
    localparam int unsigned PAY_W = 122;
    localparam int unsigned DW    = LANES * PAY_W;
    localparam int unsigned SB_W  = 2;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, out_ready;
    logic [LANES-1:0] in_lane_vld;
    logic [DW-1:0]   in_payload;
    logic [SB_W-1:0] in_sideband;

    logic            in_ready, out_valid;
    logic [LANES-1:0] out_lane_vld;
    logic [DW-1:0]   out_payload;
    logic [SB_W-1:0] out_sideband;
    logic [1:0]      occupancy;
    logic [15:0]     stall_cnt;

    logic            in_ready4, out_valid4;
    logic [LANES-1:0] out_lane_vld4;
    logic [DW-1:0]   out_payload4;
    logic [SB_W-1:0] out_sideband4;
    logic [1:0]      occupancy4;
    logic [3:0]      stall_cnt4;

    always #5 clk = ~clk;

    id_ex_skid_reg u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_payload(in_payload), .in_sideband(in_sideband),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_vld(out_lane_vld), .out_payload(out_payload), .out_sideband(out_sideband),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    id_ex_skid_reg #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_lane_vld(in_lane_vld), .in_payload(in_payload), .in_sideband(in_sideband),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_lane_vld(out_lane_vld4), .out_payload(out_payload4), .out_sideband(out_sideband4),
        .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic [LANES-1:0] lv;
        logic [DW-1:0]    pay;
        logic [SB_W-1:0]  sb;
    } bun_t;

    bun_t q[$];
    bit   m_rdy;
    int   m_stall, m_stall4;
    int   n_vec, n_err;

    function automatic logic [DW-1:0] rnd_pay();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic bun_t mk();
        bun_t b;
        b.lv  = in_lane_vld;
        b.sb  = in_sideband;
        b.pay = in_payload;
        for (int i = 0; i < int'(LANES); i++)
            if (!in_lane_vld[i]) b.pay[i*PAY_W +: PAY_W] = '0;
        return b;
    endfunction

    function automatic logic e_vld();
        return q.size() != 0;
    endfunction
    function automatic logic [DW-1:0] e_pay();
        return (q.size() != 0) ? q[0].pay : '0;
    endfunction
    function automatic logic [LANES-1:0] e_lv();
        return (q.size() != 0) ? q[0].lv : '0;
    endfunction
    function automatic logic [SB_W-1:0] e_sb();
        return (q.size() != 0) ? q[0].sb : '0;
    endfunction

    // One clock: advance the model on the rising edge, return at the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); m_rdy = 0; m_stall = 0; m_stall4 = 0;
        end else begin
            if (q.size() != 0 && !out_ready) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (flush) begin
                q.delete();
                m_rdy = 1;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && m_rdy && in_lane_vld != '0) q.push_back(mk());
                m_rdy = (q.size() < 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_lane_vld = '0; in_payload = '0; in_sideband = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; out_ready = 0;
        idle_inputs();
        q.delete(); m_rdy = 0; m_stall = 0; m_stall4 = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || out_payload !== '0 || out_lane_vld !== '0 || out_sideband !== '0) begin
            n_err++; $display("FAIL reset_outputs: got vld=%b lv=%b sb=%b, want all 0", out_valid, out_lane_vld, out_sideband); end
        n_vec++; if (occupancy !== 2'd0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_occ_rdy: got occ=%0d rdy=%b, want 0/0", occupancy, in_ready); end
        n_vec++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            n_err++; $display("FAIL reset_stall: got %0d/%0d, want 0/0", stall_cnt, stall_cnt4); end
        rst_n = 1;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_rdy_rise: got %b, want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [DW-1:0] p;
        p = '0; p[31:0] = 32'h1; p[PAY_W +: 32] = 32'hCAFE_0001;
        out_ready = 1; in_valid = 1; in_lane_vld = 2'b11; in_payload = p; in_sideband = 2'b01;
        tick();
        idle_inputs();
        n_vec++; if (out_valid !== 1'b1 || out_payload !== p || out_lane_vld !== 2'b11 || out_sideband !== 2'b01) begin
            n_err++; $display("FAIL single_out: got vld=%b lv=%b sb=%b pay=%h", out_valid, out_lane_vld, out_sideband, out_payload); end
        n_vec++; if (occupancy !== 2'd1) begin
            n_err++; $display("FAIL single_occ1: got %0d, want 1", occupancy); end
        tick();
        n_vec++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_payload !== '0) begin
            n_err++; $display("FAIL single_drain: got occ=%0d vld=%b, want 0/0", occupancy, out_valid); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] sent[3];
        int idx, acc, base;
        base = m_stall;
        for (int i = 0; i < 3; i++) sent[i] = rnd_pay();
        out_ready = 0; idx = 0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3); in_lane_vld = 2'b11; in_payload = sent[idx % 3]; in_sideband = 2'(idx);
            if (in_valid && m_rdy) begin acc++; idx++; end
            tick();
        end
        idle_inputs();
        n_vec++; if (acc !== 2 || occupancy !== 2'd2) begin
            n_err++; $display("FAIL stall_accept: got occ=%0d, want 2 (model accepts %0d)", occupancy, acc); end
        n_vec++; if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_rdy: got %b, want 0", in_ready); end
        n_vec++; if (int'(stall_cnt) !== base + 4) begin
            n_err++; $display("FAIL stall_cnt: got %0d, want %0d", stall_cnt, base + 4); end
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (out_valid !== 1'b1 || out_payload !== sent[k] || out_sideband !== 2'(k)) begin
                n_err++; $display("FAIL stall_drain%0d: got vld=%b sb=%0d pay=%h", k, out_valid, out_sideband, out_payload); end
            tick();
        end
        n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++; $display("FAIL stall_empty: got vld=%b occ=%0d", out_valid, occupancy); end
    endtask

    task automatic test_lane_mask();
        logic [DW-1:0] p;
        p = rnd_pay(); p[PAY_W-1:0] = '1;
        out_ready = 1; in_valid = 1; in_lane_vld = 2'b10; in_payload = p; in_sideband = 2'b10;
        tick();
        idle_inputs();
        n_vec++; if (out_payload[PAY_W-1:0] !== '0) begin
            n_err++; $display("FAIL mask_lane0: got %h, want 0", out_payload[PAY_W-1:0]); end
        n_vec++; if (out_payload[DW-1:PAY_W] !== p[DW-1:PAY_W] || out_lane_vld !== 2'b10) begin
            n_err++; $display("FAIL mask_lane1: got lv=%b %h, want 10 %h", out_lane_vld, out_payload[DW-1:PAY_W], p[DW-1:PAY_W]); end
        tick();
    endtask

    task automatic test_flush();
        int held;
        out_ready = 0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1; in_lane_vld = 2'b01; in_payload = rnd_pay(); in_sideband = 2'b11;
            tick();
        end
        held = m_stall;
        n_vec++; if (occupancy !== 2'd2) begin
            n_err++; $display("FAIL flush_prefill: got occ=%0d, want 2", occupancy); end
        flush = 1; in_valid = 1; out_ready = 1;
        tick();
        idle_inputs(); out_ready = 0;
        n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_payload !== '0) begin
            n_err++; $display("FAIL flush_state: got vld=%b occ=%0d rdy=%b, want 0/0/1", out_valid, occupancy, in_ready); end
        n_vec++; if (int'(stall_cnt) !== held || held == 0) begin
            n_err++; $display("FAIL flush_stall_kept: got %0d, want %0d", stall_cnt, held); end
    endtask

    task automatic test_bubble();
        out_ready = 1;
        for (int c = 0; c < 16; c++) begin
            in_valid = 1; in_lane_vld = (c % 2 == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            in_payload = rnd_pay(); in_sideband = 2'($urandom);
            tick();
            n_vec++; if (out_valid !== e_vld() || out_payload !== e_pay() || out_lane_vld !== e_lv() || in_ready !== 1'b1) begin
                n_err++; $display("FAIL bubble c%0d: got vld=%b lv=%b rdy=%b, want vld=%b lv=%b rdy=1", c, out_valid, out_lane_vld, in_ready, e_vld(), e_lv()); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 19) == 0);
            in_valid = $urandom_range(0, 1);
            in_lane_vld = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            in_payload = rnd_pay(); in_sideband = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_vec++; if (out_valid !== e_vld() || occupancy !== 2'(q.size()) || in_ready !== m_rdy) begin
                n_err++; $display("FAIL rnd_ctl c%0d: got vld=%b occ=%0d rdy=%b, want %b/%0d/%b", c, out_valid, occupancy, in_ready, e_vld(), q.size(), m_rdy); end
            n_vec++; if (out_payload !== e_pay() || out_lane_vld !== e_lv() || out_sideband !== e_sb()) begin
                n_err++; $display("FAIL rnd_data c%0d: got lv=%b sb=%b pay=%h want lv=%b sb=%b pay=%h", c, out_lane_vld, out_sideband, out_payload, e_lv(), e_sb(), e_pay()); end
            n_vec++; if (int'(stall_cnt) !== m_stall || int'(stall_cnt4) !== m_stall4) begin
                n_err++; $display("FAIL rnd_stall c%0d: got %0d/%0d, want %0d/%0d", c, stall_cnt, stall_cnt4, m_stall, m_stall4); end
        end
        idle_inputs();
    endtask

    task automatic test_sat_reset();
        out_ready = 0; in_valid = 1; in_lane_vld = 2'b11; in_payload = rnd_pay(); in_sideband = 2'b01;
        tick();
        idle_inputs();
        for (int c = 0; c < 20; c++) tick();
        n_vec++; if (stall_cnt4 !== 4'hF) begin
            n_err++; $display("FAIL sat_cnt4: got %h, want f", stall_cnt4); end
        n_vec++; if (int'(stall_cnt) !== m_stall) begin
            n_err++; $display("FAIL sat_cnt16: got %0d, want %0d", stall_cnt, m_stall); end
        #2 rst_n = 0;
        q.delete(); m_rdy = 0; m_stall = 0; m_stall4 = 0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_payload !== '0 || out_lane_vld !== '0 || out_sideband !== '0 || occupancy !== 2'd0) begin
            n_err++; $display("FAIL async_rst_data: got vld=%b occ=%0d lv=%b", out_valid, occupancy, out_lane_vld); end
        n_vec++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0 || in_ready !== 1'b0 || in_ready4 !== 1'b0) begin
            n_err++; $display("FAIL async_rst_ctl: got stall=%0d/%0d rdy=%b", stall_cnt, stall_cnt4, in_ready); end
        @(negedge clk);
        tick();
        rst_n = 1;
        tick();
        n_vec++; if (in_ready !== 1'b1 || out_valid4 !== 1'b0 || occupancy4 !== 2'd0) begin
            n_err++; $display("FAIL async_rst_release: got rdy=%b vld4=%b occ4=%0d", in_ready, out_valid4, occupancy4); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        test_reset();
        test_single();
        test_stall();
        test_lane_mask();
        test_flush();
        test_bubble();
        test_random();
        test_sat_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
